// File: rtl/vector_sweep_controller_pkg.sv
// vsc_pkg: shared state encoding and record type for the vector sweep controller (rev 1.0)
`default_nettype none

package vsc_pkg;

  localparam int MAX_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DUT_RST = 3'd1,
    SETTLE  = 3'd2,
    EMIT    = 3'd3,
    FIN     = 3'd4
  } vsc_state_t;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] vector;
    logic [MAX_WIDTH-1:0] response;
  } vsc_record_t;

endpackage

`default_nettype wire

// File: rtl/vector_sweep_controller_if.sv
// vector_sweep_controller_if: valid/ready record stream towards the result logger (rev 1.0)
`default_nettype none

interface vector_sweep_controller_if #(
  parameter int N_WIDTH   = 2,
  parameter int OUT_WIDTH = 1
);

  logic                 rec_valid;
  logic                 rec_ready;
  logic [N_WIDTH-1:0]   rec_vector;
  logic [OUT_WIDTH-1:0] rec_response;
  logic                 rec_last;

  modport master (
    output rec_valid, rec_vector, rec_response, rec_last,
    input  rec_ready
  );

  modport slave (
    input  rec_valid, rec_vector, rec_response, rec_last,
    output rec_ready
  );

endinterface

`default_nettype wire

// File: rtl/vector_sweep_controller_cycle_timer.sv
// vsc_cycle_timer: loadable down-counter; expire is high while the count sits at zero (rev 1.0)
`default_nettype none

module vsc_cycle_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expire = (count == '0);

endmodule

`default_nettype wire

// File: rtl/vector_sweep_controller.sv
// vector_sweep_controller: resets a benchmark DUT, sweeps all input vectors and streams {vector,response} records (rev 1.0)
`default_nettype none

module vector_sweep_controller
  import vsc_pkg::*;
#(
  parameter int N_WIDTH        = 2,
  parameter int OUT_WIDTH      = 1,
  parameter int SETTLE_CYCLES  = 1,
  parameter int DUT_RST_CYCLES = 1
) (
  input  logic                      CK,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      aborted,
  output logic                      dut_reset,
  output logic [N_WIDTH-1:0]        dut_n,
  input  logic [OUT_WIDTH-1:0]      dut_out,
  vector_sweep_controller_if.master rec
);

  localparam int TIMER_MAX   = (SETTLE_CYCLES > DUT_RST_CYCLES) ? SETTLE_CYCLES : DUT_RST_CYCLES;
  localparam int TIMER_WIDTH = $clog2(TIMER_MAX + 1);
  localparam logic [N_WIDTH-1:0] LAST_VEC = '1;

  vsc_state_t           state;
  vsc_state_t           state_next;
  logic [N_WIDTH-1:0]   vec;
  logic [N_WIDTH-1:0]   vec_rev;
  logic [N_WIDTH-1:0]   rec_vector_q;
  logic [OUT_WIDTH-1:0] rec_response_q;
  logic                 aborted_q;
  logic                 active;
  logic                 timer_load;
  logic [TIMER_WIDTH-1:0] timer_value;
  logic                 expire;

  assign active = (state == DUT_RST) || (state == SETTLE) || (state == EMIT);

  // The timer is reloaded on every entry into a timed state, so one counter serves both.
  assign timer_load  = (state_next != state) && ((state_next == DUT_RST) || (state_next == SETTLE));
  assign timer_value = (state_next == DUT_RST) ? TIMER_WIDTH'(DUT_RST_CYCLES - 1)
                                               : TIMER_WIDTH'(SETTLE_CYCLES - 1);

  vsc_cycle_timer #(
    .WIDTH (TIMER_WIDTH)
  ) u_timer (
    .clk        (CK),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .expire     (expire)
  );

  always_ff @(posedge CK) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DUT_RST;
      DUT_RST: if (abort) state_next = FIN; else if (expire) state_next = SETTLE;
      SETTLE:  if (abort) state_next = FIN; else if (expire) state_next = EMIT;
      EMIT: begin
        if (abort) begin
          state_next = FIN;
        end else if (rec.rec_ready) begin
          state_next = (vec == LAST_VEC) ? FIN : SETTLE;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (!reset) begin
      vec            <= '0;
      rec_vector_q   <= '0;
      rec_response_q <= '0;
      aborted_q      <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        vec       <= '0;
        aborted_q <= 1'b0;
      end
      if (active && abort) begin
        aborted_q <= 1'b1;
      end
      if (state == SETTLE && expire && !abort) begin
        rec_vector_q   <= vec;
        rec_response_q <= dut_out;
      end
      // Terminal compare stops the sweep before vec could wrap back to zero.
      if (state == EMIT && !abort && rec.rec_ready && vec != LAST_VEC) begin
        vec <= vec + N_WIDTH'(1);
      end
    end
  end

  // dut_n[0] carries the MSB of the sweep count.
  always_comb begin
    vec_rev = '0;
    for (int i = 0; i < N_WIDTH; i++) begin
      vec_rev[i] = vec[N_WIDTH-1-i];
    end
  end

  always_comb begin
    busy          = (state != IDLE);
    done          = (state == FIN);
    aborted       = (state == FIN) && aborted_q;
    dut_reset     = (state == DUT_RST);
    rec.rec_valid = (state == EMIT);
    dut_n         = '0;
    if (state == SETTLE || state == EMIT || state == FIN) begin
      dut_n = vec_rev;
    end
  end

  assign rec.rec_vector   = rec_vector_q;
  assign rec.rec_response = rec_response_q;
  assign rec.rec_last     = (state == EMIT) && (rec_vector_q == LAST_VEC);

endmodule

`default_nettype wire
